// File: rtl/hazard_pkg.sv
// Shared types and constants for the data-hazard / forwarding controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int STALL_CNT_W = 32;
  localparam int RD_W        = 8;

  // rd is stored at a fixed width; narrower indices are zero-extended
  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memread;
    logic [RD_W-1:0] rd;
  } shadow_t;

  function automatic logic is_producer(shadow_t e);
    return e.valid & e.regwrite & (e.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source compare against the shadow pipeline.
// Optional WB->ID bypass enabled by HAZARD_ID_BYPASS_EN.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic             used,
  input  shadow_t          s_ex,
  input  shadow_t          s_mem,
  input  shadow_t          s_wb,
  output logic [1:0]       next_sel,
  output logic             load_use,
  output logic             bypass
);

  logic [RD_W-1:0] rs_x;
  logic            ex_hit;
  logic            mem_hit;

  assign rs_x    = RD_W'(rs);
  assign ex_hit  = used & is_producer(s_ex)
                 & (s_ex.rd == rs_x);
  assign mem_hit = used & is_producer(s_mem)
                 & (s_mem.rd == rs_x);

  assign load_use = ex_hit & s_ex.memread;

  always_comb begin
    next_sel = FWD_RF;
    unique case (1'b1)
      (ex_hit && !s_ex.memread): next_sel = FWD_MEM;
      (!ex_hit && mem_hit):      next_sel = FWD_WB;
      default:                   next_sel = FWD_RF;
    endcase
  end

`ifdef HAZARD_ID_BYPASS_EN
  logic unused_fields;
  assign bypass = used & is_producer(s_wb)
                & (s_wb.rd == rs_x);
  assign unused_fields = ^{s_mem.memread,
                           s_wb.memread};
`else
  // WB matches are served by the write-before-read regfile
  logic unused_fields;
  assign bypass = 1'b0;
  assign unused_fields = ^{s_mem.memread, s_wb};
`endif

endmodule

// File: rtl/hazard_fwd_unit.sv
// Data-hazard controller: shadow EX/MEM/WB tracking, load-use stall,
// registered forwarding selects. Optional HAZARD_ID_BYPASS_EN.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int NSRC  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   ex_flush,
  input  logic                   id_valid,
  input  logic [NSRC*REG_W-1:0]  id_rs,
  input  logic [NSRC-1:0]        id_rs_used,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  output logic                   stall_id,
  output logic [NSRC*2-1:0]      ex_fwd_sel,
  output logic [NSRC-1:0]        id_bypass,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  shadow_t s_ex, s_mem, s_wb;
  shadow_t id_ent;

  logic [NSRC*2-1:0] next_sel;
  logic [NSRC-1:0]   load_use;

  assign id_ent = '{
    valid:    id_valid,
    regwrite: id_regwrite,
    memread:  id_memread,
    rd:       RD_W'(id_rd)
  };

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    hazard_src_match #(
      .REG_W(REG_W)
    ) u_match (
      .rs       (id_rs[i*REG_W +: REG_W]),
      .used     (id_rs_used[i]),
      .s_ex     (s_ex),
      .s_mem    (s_mem),
      .s_wb     (s_wb),
      .next_sel (next_sel[i*2 +: 2]),
      .load_use (load_use[i]),
      .bypass   (id_bypass[i])
    );
  end

  assign stall_id = id_valid & (|load_use)
                  & ~ex_flush & ~hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ex       <= '0;
      s_mem      <= '0;
      s_wb       <= '0;
      ex_fwd_sel <= '0;
      stall_cnt  <= '0;
    end else if (!hold) begin
      s_mem <= s_ex;
      s_wb  <= s_mem;
      if (ex_flush || stall_id) begin
        s_ex       <= '0;
        ex_fwd_sel <= '0;
      end else begin
        s_ex       <= id_ent;
        ex_fwd_sel <= next_sel;
      end
      if (stall_id && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit.
// Expectations track HAZARD_ID_BYPASS_EN for id_bypass.
module tb_hazard_fwd_unit;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        ex_flush;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        stall_id;
  logic [3:0]  ex_fwd_sel;
  logic [1:0]  id_bypass;
  logic [31:0] stall_cnt;

  int n_vec;
  int n_err;

`ifdef HAZARD_ID_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  hazard_fwd_unit #(
    .REG_W(5),
    .NSRC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .ex_flush   (ex_flush),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .stall_id   (stall_id),
    .ex_fwd_sel (ex_fwd_sel),
    .id_bypass  (id_bypass),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic       v,
                       input logic [4:0] r1,
                       input logic [4:0] r2,
                       input logic [1:0] used,
                       input logic [4:0] rd,
                       input logic       rw,
                       input logic       mr);
    id_valid    = v;
    id_rs       = {r2, r1};
    id_rs_used  = used;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    hold     = 1'b0;
    ex_flush = 1'b0;
    issue(0, 0, 0, 2'b00, 0, 0, 0);
    tick;
    tick;
    check("rst_sel", 32'(ex_fwd_sel), 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_stall", 32'(stall_id), 0);
    check("rst_byp", 32'(id_bypass), 0);
    rst = 1'b0;

    // distance 1: ALU x5 -> reader rs1=x5
    issue(1, 0, 0, 2'b00, 5, 1, 0); tick;
    issue(1, 5, 0, 2'b01, 0, 0, 0); #1;
    check("d1_stall", 32'(stall_id), 0);
    tick;
    check("d1_sel", 32'(ex_fwd_sel), 4'b0010);

    // distance 2
    issue(1, 0, 0, 2'b00, 6, 1, 0); tick;
    issue(0, 0, 0, 2'b00, 0, 0, 0); tick;
    issue(1, 6, 0, 2'b01, 0, 0, 0); #1;
    check("d2_stall", 32'(stall_id), 0);
    tick;
    check("d2_sel", 32'(ex_fwd_sel), 4'b0001);

    // distance 3
    issue(1, 0, 0, 2'b00, 9, 1, 0); tick;
    issue(0, 0, 0, 2'b00, 0, 0, 0); tick;
    tick;
    issue(1, 9, 0, 2'b01, 0, 0, 0); #1;
    check("d3_byp", 32'(id_bypass), {31'd0, BYP});
    tick;
    check("d3_sel", 32'(ex_fwd_sel), 4'b0000);

    // load x7 -> reader rs2=x7
    issue(1, 0, 0, 2'b00, 7, 1, 1); tick;
    issue(1, 0, 7, 2'b10, 0, 0, 0); #1;
    check("lu_stall", 32'(stall_id), 1);
    tick;
    check("lu_bubble_sel", 32'(ex_fwd_sel), 0);
    check("lu_cnt", stall_cnt, 1);
    check("lu_release", 32'(stall_id), 0);
    tick;
    check("lu_sel", 32'(ex_fwd_sel), 4'b0100);

    // x0 load producer never stalls or forwards
    issue(1, 0, 0, 2'b00, 0, 1, 1); tick;
    issue(1, 0, 0, 2'b11, 0, 0, 0); #1;
    check("x0_stall", 32'(stall_id), 0);
    tick;
    check("x0_sel", 32'(ex_fwd_sel), 0);

    // x3 written twice, youngest wins on both sources
    issue(1, 0, 0, 2'b00, 3, 1, 0); tick;
    tick;
    issue(1, 3, 3, 2'b11, 0, 0, 0); tick;
    check("young_sel", 32'(ex_fwd_sel), 4'b1010);

    // load-use coinciding with flush
    issue(1, 0, 0, 2'b00, 8, 1, 1); tick;
    issue(1, 8, 0, 2'b01, 8, 1, 0);
    ex_flush = 1'b1; #1;
    check("fl_stall", 32'(stall_id), 0);
    tick;
    ex_flush = 1'b0;
    check("fl_sel", 32'(ex_fwd_sel), 0);
    issue(1, 8, 0, 2'b01, 0, 0, 0); #1;
    check("fl_after_stall", 32'(stall_id), 0);
    tick;
    check("fl_after_sel", 32'(ex_fwd_sel), 4'b0001);
    check("fl_cnt", stall_cnt, 1);

    // hold for 4 cycles in the middle of a stall
    issue(1, 0, 0, 2'b00, 11, 1, 0); tick;
    issue(1, 11, 0, 2'b01, 10, 1, 1); tick;
    check("hd_pre_sel", 32'(ex_fwd_sel), 4'b0010);
    issue(1, 0, 10, 2'b10, 0, 0, 0); #1;
    check("hd_stall", 32'(stall_id), 1);
    hold = 1'b1; #1;
    check("hd_gated", 32'(stall_id), 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("hd_sel", 32'(ex_fwd_sel), 4'b0010);
      check("hd_cnt", stall_cnt, 1);
    end
    hold = 1'b0; #1;
    check("hd_restall", 32'(stall_id), 1);
    tick;
    check("hd_cnt2", stall_cnt, 2);
    check("hd_bub_sel", 32'(ex_fwd_sel), 0);
    tick;
    check("hd_sel2", 32'(ex_fwd_sel), 4'b0100);

    // reset with a producer in flight
    issue(1, 0, 0, 2'b00, 12, 1, 0); tick;
    issue(1, 12, 0, 2'b01, 0, 0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rr_sel", 32'(ex_fwd_sel), 0);
    check("rr_cnt", stall_cnt, 0);
    tick;
    check("rr_first_sel", 32'(ex_fwd_sel), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised data-hazard controller for the 5-stage pipeline, replacing the per-operand combinational forwarding compare. It tracks every in-flight producer in an internal shadow pipeline (EX, MEM, WB) and detects load-use hazards, driving the stall and bubble. It registers per-source forwarding selects so they are stable for the whole EX cycle. It sits beside the ID/EX register and is fed only with ID-stage decode plus global hold/flush.

## Interface
- REG_W, 5, register-index width
- NSRC, 2, number of source operands per instruction (1..4)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  global freeze (e.g. dmem wait); all internal state holds
- ex_flush  in  1  taken branch/jump resolved in EX; kills ID instruction
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NSRC*REG_W  source indices, source i at [i*REG_W +: REG_W]
- id_rs_used  in  NSRC  source i is actually read
- id_rd  in  REG_W  destination index
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- stall_id  out  1  hold PC and IF/ID; insert bubble into ID/EX (combinational)
- ex_fwd_sel  out  NSRC*2  registered select per source, valid in EX: 00 regfile, 10 MEM aluout, 01 WB write data
- id_bypass  out  NSRC  WB->ID same-cycle bypass (macro only, else tied 0)
- stall_cnt  out  32  saturating count of load-use stall cycles

## Operation
- Shadow entry = {valid, regwrite, memread, rd}. Three entries: S_EX, S_MEM, S_WB. An entry is a producer only if valid & regwrite & rd != 0. Writes to x0 never forward or stall.
- Per source i (only if id_rs_used[i]), compared against the ID-time view:
  - S_EX producer with rd == rs_i, not a load: next select 10.
  - S_EX producer with rd == rs_i and memread: load-use hazard; stall_id = 1.
  - Else S_MEM producer with rd == rs_i: next select 01.
  - Else 00. S_EX always has priority over S_MEM (youngest wins).
- stall_id = id_valid & any source load-use hazard & ~ex_flush & ~hold.
- Per-cycle update, in priority order:
  - hold = 1: all state holds.
  - ex_flush = 1: S_EX <- invalid and ex_fwd_sel <- 0. S_MEM <- S_EX, S_WB <- S_MEM.
  - stall_id = 1: S_EX <- invalid (bubble), ex_fwd_sel <- 0, shift S_EX->S_MEM->S_WB, stall_cnt += 1 (saturates at 2^32-1).
  - Otherwise: S_EX <- ID fields (valid = id_valid), ex_fwd_sel <- computed selects, shift.
- A stalled load-use resolves after exactly one cycle: the load moves to S_MEM, and the re-evaluated select is 01.
- Reset: all shadow valid = 0, ex_fwd_sel = 0, stall_cnt = 0. id_bypass = 0 and stall_id = 0 as a consequence.
- Reset mid-operation discards all in-flight producers. The first instruction after reset reads the regfile.

## Timing
- Select computed in the ID cycle of instruction N and registered on the ID->EX edge. Zero combinational path from the ID/EX register to the ALU mux.
- Load-use penalty is exactly 1 cycle. Back-to-back ALU dependencies have 0 penalty.
- stall_id is combinational from the current inputs and shadow state within the same cycle.
- While hold = 1, ex_fwd_sel keeps its value for the whole hold, however long.

## Configuration
- HAZARD_ID_BYPASS_EN defined:
  - id_bypass[i] = 1 when S_WB is a producer with rd == rs_i and id_rs_used[i].
  - The ID stage muxes the WB write data into the operand read.
- Undefined:
  - id_bypass is tied 0.
  - The regfile is write-before-read. The unit issues no select for S_WB matches.

## Structure
- Shared package hazard_pkg:
  - FWD_RF = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01.
  - Shadow-entry typedef.
  - STALL_CNT_W = 32.
- One sub-module, hazard_src_match. It holds the per-source compare logic and produces the next select, the load-use flag and the bypass bit. It is instantiated NSRC times via generate.

## Test plan
- ALU write x5 then the next instruction reads rs1 = x5: 0 stall, ex_fwd_sel[1:0] = 10 in EX. At distance 2: 01. At distance 3: 00 (id_bypass[0] = 1 with the macro).
- Load writing x7 followed by a read of rs2 = x7: stall_id = 1 for one cycle and a bubble enters EX. Then ex_fwd_sel[3:2] = 01 and stall_cnt = 1.
- Producer with rd = x0 followed by a read of x0: selects 00 and no stall.
- Write x3 in two consecutive instructions, then a reader of x3: select 10 (youngest wins).
- Load-use hazard coinciding with ex_flush = 1: no stall, S_EX invalid next cycle. Hold asserted for 4 cycles mid-stall: stall_cnt and selects unchanged across the hold.
- rst = 1 for one cycle with valid producers in flight: all selects 00 and stall_cnt = 0 on the next cycle.
